// File: rtl/mux_arb_pkg.sv
// Shared constants, state encoding and helpers for the 4-way
// round-robin arbiter with its shared 4:1 data mux.
package mux_arb_pkg;

    localparam int NUM_REQ      = 4;
    localparam int SEL_W        = 2;
    localparam int HOLD_W       = 4;
    localparam int MAX_HOLD_DEF = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    function automatic logic [NUM_REQ-1:0] onehot(
        input logic [SEL_W-1:0] idx
    );
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority picker: scans ptr, ptr+1, ptr+2, ptr+3 (mod 4)
// and returns the first request not masked out.
module rr_pick4
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    input  logic [NUM_REQ-1:0] exclude_mask,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);

    logic [NUM_REQ-1:0] elig;
    logic [SEL_W-1:0]   cand;

    assign elig = req & ~exclude_mask;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = ptr + SEL_W'(i);
            if (!found && elig[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Four-requester round-robin arbiter with bounded hold time; the
// granted requester's data bit is steered combinationally onto y.
module mux4_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] din,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   sel,
    output logic               y,
    output logic               busy
);

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;

    logic [NUM_REQ-1:0] excl;
    logic               pick_found;
    logic [SEL_W-1:0]   pick_idx;
    logic               grant_new;

    // The current owner only competes when nobody holds the resource.
    assign excl = (state_q == GRANT) ? onehot(sel_q) : '0;

    rr_pick4 u_pick (
        .req          (req),
        .ptr          (ptr_q),
        .exclude_mask (excl),
        .found        (pick_found),
        .idx          (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        grant_new = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_new = 1'b1;
                end
            end
            GRANT: begin
                if (!req[sel_q]) begin
                    if (pick_found) begin
                        grant_new = 1'b1;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        hold_d  = '0;
                    end
                end else if (hold_q < HOLD_MAX) begin
                    hold_d = hold_q + 1'b1;
                end else if (pick_found) begin
                    grant_new = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                hold_d  = '0;
            end
        endcase

        if (grant_new) begin
            state_d = GRANT;
            gnt_d   = onehot(pick_idx);
            sel_d   = pick_idx;
            ptr_d   = pick_idx + 1'b1;
            hold_d  = HOLD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    assign gnt  = gnt_q;
    assign sel  = sel_q;
    assign busy = (state_q == GRANT);
    assign y    = busy & din[sel_q];

endmodule
